// File: rtl/expr_string_gen_if.sv
// Token-in / character-out bus of the ASCII expression-string generator.
// Both streams use the same handshake: a transfer happens on a rising clock edge
// where valid and ready are both high. A producer holds valid and its payload
// steady until the transfer happens.
interface expr_string_gen_if #(
   parameter int NUM_W = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [NUM_W-1:0] in_num;
   logic [1:0]       in_op;
   logic             out_valid;
   logic             out_ready;
   logic [7:0]       out_char;
   logic             busy;

   modport master (
      output in_valid, in_num, in_op, out_ready,
      input  in_ready, out_valid, out_char, busy
   );

   modport slave (
      input  in_valid, in_num, in_op, out_ready,
      output in_ready, out_valid, out_char, busy
   );
endinterface

// File: rtl/expr_string_gen.sv
// Turns (operand, operator) tokens into an ASCII byte stream: decimal digits
// MSD first, then '+', '*', '?' or NUL.
module expr_string_gen #(
   parameter int NUM_W      = 16,
   parameter int MAX_DIGITS = 5
) (
   input  logic                 clk,
   input  logic                 clr,
   expr_string_gen_if.slave     bus,
   output logic [1:0]           o_state
);
   localparam int CW = $clog2(MAX_DIGITS);

   typedef enum logic [1:0] {IDLE, CONV, EMIT_DIG, EMIT_OP} state_t;

   state_t           r_state;
   state_t           w_next;
   logic [NUM_W-1:0] r_val;
   logic [1:0]       r_op;
   logic [CW-1:0]    r_cnt;
   logic [CW-1:0]    r_idx;
   logic [3:0]       r_dig [MAX_DIGITS];

   logic [NUM_W-1:0] w_quot;
   logic [3:0]       w_rem;
   logic             w_out_valid;
   logic [7:0]       w_out_char;

   assign w_quot = r_val / NUM_W'(10);
   assign w_rem  = 4'(r_val % NUM_W'(10));

   always_ff @(posedge clk or posedge clr) begin
      if (clr) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next      = r_state;
      w_out_valid = 1'b0;
      w_out_char  = 8'h00;
      case (r_state)
         IDLE: begin
            if (bus.in_valid) w_next = CONV;
         end
         CONV: begin
            if (w_quot == '0) w_next = EMIT_DIG;
         end
         EMIT_DIG: begin
            w_out_valid = 1'b1;
            w_out_char  = 8'h30 + {4'h0, r_dig[r_idx]};
            if (bus.out_ready && r_idx == '0) w_next = EMIT_OP;
         end
         EMIT_OP: begin
            w_out_valid = 1'b1;
            case (r_op)
               2'b00:   w_out_char = 8'h00;
               2'b01:   w_out_char = 8'h2B;
               2'b10:   w_out_char = 8'h2A;
               default: w_out_char = 8'h3F;
            endcase
            if (bus.out_ready) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   // Digits land LSD-first at r_cnt; r_idx then walks back down for MSD-first output.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_val <= '0;
         r_op  <= '0;
         r_cnt <= '0;
         r_idx <= '0;
         for (int i = 0; i < MAX_DIGITS; i++) r_dig[i] <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.in_valid) begin
                  r_val <= bus.in_num;
                  r_op  <= bus.in_op;
                  r_cnt <= '0;
               end
            end
            CONV: begin
               r_dig[r_cnt] <= w_rem;
               r_val        <= w_quot;
               r_cnt        <= r_cnt + CW'(1);
               if (w_quot == '0) r_idx <= r_cnt;
            end
            EMIT_DIG: begin
               if (bus.out_ready && r_idx != '0) r_idx <= r_idx - CW'(1);
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = (r_state == IDLE) && !clr;
   assign bus.out_valid = w_out_valid;
   assign bus.out_char  = w_out_char;
   assign bus.busy      = (r_state != IDLE);
   assign o_state       = r_state;
endmodule

// File: tb/tb_expr_string_gen.sv
// Directed bench for expr_string_gen: table of tokens with hand-written
// expected strings, plus reset-abort and back-to-back token sequences.
module tb_expr_string_gen;
   logic       clk;
   logic       clr;
   logic [1:0] state;
   int         checks;
   int         errors;
   logic [7:0] exp_q[$];

   expr_string_gen_if #(.NUM_W(16)) bus ();

   expr_string_gen #(.NUM_W(16), .MAX_DIGITS(5)) dut (
      .clk     (clk),
      .clr     (clr),
      .bus     (bus),
      .o_state (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] num;
      logic [1:0]  op;
      logic [55:0] str;
      int          nch;
      int          conv;
      int          stall;
   } vec_t;

   vec_t vecs [7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic load_exp(input logic [55:0] str, input int nch);
      exp_q.delete();
      for (int i = 0; i < nch; i++) exp_q.push_back(str[8*(nch-1-i) +: 8]);
   endtask

   task automatic send_token(input logic [15:0] num, input logic [1:0] op);
      int g;
      g = 0;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_num   = num;
      bus.in_op    = op;
      #1;
      while (!bus.in_ready && g < 50) begin
         @(negedge clk);
         #1;
         g++;
      end
      check("accept_ready", 32'(bus.in_ready), 32'd1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   // Drains exp_q from the output stream; stall_mode applies a ready pattern 0,0,1.
   task automatic collect(input string name, input int stall_mode, input int exp_conv);
      int         conv;
      int         k;
      int         guard;
      logic       stalled;
      logic [7:0] held;
      logic [7:0] e;
      conv = 0; k = 0; guard = 0; stalled = 1'b0; held = 8'h00;
      while (exp_q.size() > 0 && guard < 200) begin
         @(negedge clk);
         guard++;
         bus.out_ready = (stall_mode == 0) ? 1'b1 : (k % 3 == 2);
         #1;
         if (stalled) begin
            check({name, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
            check({name, "_hold_char"}, 32'(bus.out_char), 32'(held));
         end
         stalled = 1'b0;
         if (bus.busy && !bus.out_valid) begin
            conv++;
            check({name, "_conv_char"}, 32'(bus.out_char), 32'h0);
         end
         if (bus.out_valid) begin
            k++;
            if (bus.out_ready) begin
               e = exp_q.pop_front();
               check({name, "_char"}, 32'(bus.out_char), 32'(e));
            end else begin
               stalled = 1'b1;
               held    = bus.out_char;
            end
         end
      end
      check({name, "_in_time"}, 32'(guard < 200), 32'd1);
      check({name, "_conv_cycles"}, 32'(conv), 32'(exp_conv));
      @(negedge clk);
      bus.out_ready = 1'b1;
      #1;
      check({name, "_ready_after"}, 32'(bus.in_ready), 32'd1);
      check({name, "_busy_after"}, 32'(bus.busy), 32'd0);
   endtask

   initial begin
      int         accepted;
      int         tok_i;
      int         guard;
      logic [15:0] tnum [3];
      logic [1:0]  top  [3];
      logic [7:0]  e;

      checks = 0;
      errors = 0;
      clr = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_num    = '0;
      bus.in_op     = '0;
      bus.out_ready = 1'b1;

      vecs[0] = '{16'd7,     2'b01, 56'h372B,         2, 1, 0};
      vecs[1] = '{16'd0,     2'b00, 56'h3000,         2, 1, 0};
      vecs[2] = '{16'd65535, 2'b10, 56'h36353533352A, 6, 5, 0};
      vecs[3] = '{16'd12,    2'b01, 56'h31322B,       3, 2, 1};
      vecs[4] = '{16'd10,    2'b11, 56'h31303F,       3, 2, 0};
      vecs[5] = '{16'd9000,  2'b01, 56'h393030302B,   5, 4, 0};
      vecs[6] = '{16'd100,   2'b10, 56'h3130302A,     4, 3, 1};

      #12;
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_out_char", 32'(bus.out_char), 32'h0);
      check("rst_in_ready", 32'(bus.in_ready), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_state", 32'(state), 32'd0);
      @(negedge clk);
      clr = 1'b0;
      #1;
      check("idle_in_ready", 32'(bus.in_ready), 32'd1);

      for (int v = 0; v < 7; v++) begin
         load_exp(vecs[v].str, vecs[v].nch);
         send_token(vecs[v].num, vecs[v].op);
         collect($sformatf("vec%0d", v), vecs[v].stall, vecs[v].conv);
      end

      // Abort 123 after its '1' is taken, then check a clean restart.
      send_token(16'd123, 2'b00);
      guard = 0;
      do begin
         @(negedge clk);
         #1;
         guard++;
      end while (!(bus.out_valid && bus.out_char == 8'h31) && guard < 50);
      check("abort_saw_1", 32'(bus.out_char), 32'h31);
      @(posedge clk);
      #1;
      clr = 1'b1;
      #1;
      check("abort_out_valid", 32'(bus.out_valid), 32'd0);
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_in_ready", 32'(bus.in_ready), 32'd0);
      @(negedge clk);
      clr = 1'b0;
      load_exp(56'h3400, 2);
      send_token(16'd4, 2'b00);
      collect("after_clr", 0, 1);

      // Back-to-back tokens, next token held on in_valid while busy.
      tnum[0] = 16'd12; top[0] = 2'b01;
      tnum[1] = 16'd3;  top[1] = 2'b10;
      tnum[2] = 16'd4;  top[2] = 2'b00;
      load_exp(56'h31322B332A3400, 7);
      accepted = 0; tok_i = 0; guard = 0;
      while (exp_q.size() > 0 && guard < 300) begin
         @(negedge clk);
         guard++;
         bus.out_ready = 1'b1;
         if (tok_i < 3) begin
            bus.in_valid = 1'b1;
            bus.in_num   = tnum[tok_i];
            bus.in_op    = top[tok_i];
         end else begin
            bus.in_valid = 1'b0;
         end
         #1;
         if (bus.in_valid && bus.in_ready) begin
            accepted++;
            tok_i++;
         end
         if (bus.out_valid) begin
            e = exp_q.pop_front();
            check("stream_char", 32'(bus.out_char), 32'(e));
         end
      end
      check("stream_in_time", 32'(guard < 300), 32'd1);
      @(negedge clk);
      bus.in_valid = 1'b0;
      #1;
      check("stream_tokens", 32'(accepted), 32'd3);
      for (int i = 0; i < 3; i++) begin
         check("stream_no_extra", 32'(bus.out_valid), 32'd0);
         @(negedge clk);
         #1;
      end
      check("stream_idle", 32'(bus.in_ready), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
